// File: rtl/ps2_key_decoder_pkg.sv
// rtl/ps2_key_decoder_pkg.sv - PS/2 set-2 scan-code constants, prefix states and ASCII translation
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  localparam logic [7:0] ASC_UP    = 8'h11;
  localparam logic [7:0] ASC_LEFT  = 8'h12;
  localparam logic [7:0] ASC_DOWN  = 8'h13;
  localparam logic [7:0] ASC_RIGHT = 8'h14;
  localparam logic [7:0] ASC_ESC   = 8'h1B;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_TAB   = 8'h09;
  localparam logic [7:0] ASC_SPACE = 8'h20;

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} prefix_state_t;

  // Lowercase letter for a letter key, 00 for anything else.
  function automatic logic [7:0] letter_of(input logic [7:0] code);
    case (code)
      8'h1C: letter_of = 8'h61;  8'h32: letter_of = 8'h62;  8'h21: letter_of = 8'h63;
      8'h23: letter_of = 8'h64;  8'h24: letter_of = 8'h65;  8'h2B: letter_of = 8'h66;
      8'h34: letter_of = 8'h67;  8'h33: letter_of = 8'h68;  8'h43: letter_of = 8'h69;
      8'h3B: letter_of = 8'h6A;  8'h42: letter_of = 8'h6B;  8'h4B: letter_of = 8'h6C;
      8'h3A: letter_of = 8'h6D;  8'h31: letter_of = 8'h6E;  8'h44: letter_of = 8'h6F;
      8'h4D: letter_of = 8'h70;  8'h15: letter_of = 8'h71;  8'h2D: letter_of = 8'h72;
      8'h1B: letter_of = 8'h73;  8'h2C: letter_of = 8'h74;  8'h3C: letter_of = 8'h75;
      8'h2A: letter_of = 8'h76;  8'h1D: letter_of = 8'h77;  8'h22: letter_of = 8'h78;
      8'h35: letter_of = 8'h79;  8'h1A: letter_of = 8'h7A;
      default: letter_of = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] translate(input logic [7:0] code, input logic ext,
                                           input logic shift, input logic caps);
    logic [7:0] letter;
    translate = 8'h00;
    letter = letter_of(code);
    if (ext) begin
      case (code)
        8'h75: translate = ASC_UP;
        8'h6B: translate = ASC_LEFT;
        8'h72: translate = ASC_DOWN;
        8'h74: translate = ASC_RIGHT;
        8'h5A: translate = ASC_CR;
        8'h4A: translate = 8'h2F;
        default: translate = 8'h00;
      endcase
    end else if (letter != 8'h00) begin
      translate = (shift ^ caps) ? letter - 8'h20 : letter;
    end else begin
      case (code)
        8'h16: translate = shift ? 8'h21 : 8'h31;
        8'h1E: translate = shift ? 8'h40 : 8'h32;
        8'h26: translate = shift ? 8'h23 : 8'h33;
        8'h25: translate = shift ? 8'h24 : 8'h34;
        8'h2E: translate = shift ? 8'h25 : 8'h35;
        8'h36: translate = shift ? 8'h5E : 8'h36;
        8'h3D: translate = shift ? 8'h26 : 8'h37;
        8'h3E: translate = shift ? 8'h2A : 8'h38;
        8'h46: translate = shift ? 8'h28 : 8'h39;
        8'h45: translate = shift ? 8'h29 : 8'h30;
        8'h0E: translate = shift ? 8'h7E : 8'h60;
        8'h4E: translate = shift ? 8'h5F : 8'h2D;
        8'h55: translate = shift ? 8'h2B : 8'h3D;
        8'h54: translate = shift ? 8'h7B : 8'h5B;
        8'h5B: translate = shift ? 8'h7D : 8'h5D;
        8'h5D: translate = shift ? 8'h7C : 8'h5C;
        8'h4C: translate = shift ? 8'h3A : 8'h3B;
        8'h52: translate = shift ? 8'h22 : 8'h27;
        8'h41: translate = shift ? 8'h3C : 8'h2C;
        8'h49: translate = shift ? 8'h3E : 8'h2E;
        8'h4A: translate = shift ? 8'h3F : 8'h2F;
        8'h76: translate = ASC_ESC;
        8'h5A: translate = ASC_CR;
        8'h29: translate = ASC_SPACE;
        8'h66: translate = ASC_BS;
        8'h0D: translate = ASC_TAB;
        default: translate = 8'h00;
      endcase
    end
  endfunction

endpackage

// File: rtl/ps2_key_decoder_key_fifo.sv
// rtl/ps2_key_decoder_key_fifo.sv - first-word-fall-through FIFO with full/empty and drop pulse
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 decoder: prefix FSM, modifiers, held-key filter, char FIFO
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int REPEAT_EN  = 1,
  parameter int CTRL_EN    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] char_ascii,
  output logic       char_rdy,
  input  logic       char_rd,
  output logic       fifo_full,
  output logic       overflow,
  output logic       shift_o,
  output logic       ctrl_o,
  output logic       caps_o
);
  prefix_state_t state;
  logic       lshift, rshift, lctrl, rctrl, caps, caps_held;
  logic       held_valid, held_ext;
  logic [7:0] held_code;
  logic       is_prefix, is_noise, ev_ext, make_ev, brk_ev, is_repeat, push, empty;
  logic [7:0] letter, ch;

  assign shift_o = lshift | rshift;
  assign ctrl_o  = lctrl | rctrl;
  assign caps_o  = caps;

  always_comb begin
    is_prefix = (scan_code == SC_BREAK) || (scan_code == SC_EXT);
    is_noise  = (scan_code == SC_BAT_OK) || (scan_code == SC_ACK) ||
                (scan_code == SC_ECHO) || (scan_code == SC_RESEND);
    ev_ext    = (state == ST_EXT) || (state == ST_EXT_BRK);
    make_ev   = scan_valid && !is_prefix &&
                ((state == ST_IDLE && !is_noise) || state == ST_EXT);
    brk_ev    = scan_valid && !is_prefix && (state == ST_BRK || state == ST_EXT_BRK);
    letter    = letter_of(scan_code);
    ch        = translate(scan_code, ev_ext, shift_o, caps);
    if (CTRL_EN != 0 && ctrl_o && !ev_ext && letter != 8'h00)
      ch = (letter - 8'h20) & 8'h1F;
    is_repeat = held_valid && (held_ext == ev_ext) && (held_code == scan_code);
    push      = make_ev && (ch != 8'h00) && (REPEAT_EN != 0 || !is_repeat);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      lctrl      <= 1'b0;
      rctrl      <= 1'b0;
      caps       <= 1'b0;
      caps_held  <= 1'b0;
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= 8'h00;
    end else if (scan_valid) begin
      if (scan_code == SC_EXT)
        state <= ST_EXT;
      else if (scan_code == SC_BREAK)
        state <= ev_ext ? ST_EXT_BRK : ST_BRK;
      else
        state <= ST_IDLE;

      if (make_ev) begin
        if (!ev_ext && scan_code == SC_LSHIFT) lshift <= 1'b1;
        if (!ev_ext && scan_code == SC_RSHIFT) rshift <= 1'b1;
        if (!ev_ext && scan_code == SC_CTRL)   lctrl  <= 1'b1;
        if (ev_ext  && scan_code == SC_CTRL)   rctrl  <= 1'b1;
        if (!ev_ext && scan_code == SC_CAPS) begin
          caps_held <= 1'b1;
          if (!caps_held) caps <= !caps;
        end
        // Any non-repeat make replaces the held key; only a pushed one arms the filter.
        if (!is_repeat) begin
          held_valid <= push;
          held_ext   <= ev_ext;
          held_code  <= scan_code;
        end
      end

      if (brk_ev) begin
        if (!ev_ext && scan_code == SC_LSHIFT) lshift    <= 1'b0;
        if (!ev_ext && scan_code == SC_RSHIFT) rshift    <= 1'b0;
        if (!ev_ext && scan_code == SC_CTRL)   lctrl     <= 1'b0;
        if (ev_ext  && scan_code == SC_CTRL)   rctrl     <= 1'b0;
        if (!ev_ext && scan_code == SC_CAPS)   caps_held <= 1'b0;
        if (is_repeat) held_valid <= 1'b0;
      end
    end
  end

  key_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (ch),
    .pop      (char_rd),
    .dout     (char_ascii),
    .full     (fifo_full),
    .empty    (empty),
    .overflow (overflow)
  );

  assign char_rdy = !empty;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - table-driven scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sc  [2];
  logic       sv  [2];
  logic       rd  [2];
  logic [7:0] asc [2];
  logic       rdy [2], full [2], ovf [2], sh [2], ct [2], cp [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  typedef struct {
    int         d;
    logic [7:0] code;
    logic       push;
    logic [7:0] ch;
    logic       drain;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(4), .REPEAT_EN(1), .CTRL_EN(1)) u_dut (
    .clk(clk), .rst(rst), .scan_code(sc[0]), .scan_valid(sv[0]),
    .char_ascii(asc[0]), .char_rdy(rdy[0]), .char_rd(rd[0]),
    .fifo_full(full[0]), .overflow(ovf[0]),
    .shift_o(sh[0]), .ctrl_o(ct[0]), .caps_o(cp[0])
  );

  ps2_key_decoder #(.FIFO_DEPTH(8), .REPEAT_EN(0), .CTRL_EN(1)) u_norep (
    .clk(clk), .rst(rst), .scan_code(sc[1]), .scan_valid(sv[1]),
    .char_ascii(asc[1]), .char_rdy(rdy[1]), .char_rd(rd[1]),
    .fifo_full(full[1]), .overflow(ovf[1]),
    .shift_o(sh[1]), .ctrl_o(ct[1]), .caps_o(cp[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input int d, input logic [7:0] ch);
    if (d == 0) exp0.push_back(ch); else exp1.push_back(ch);
  endtask

  task automatic exp_pop(input int d, output logic [7:0] ch, output logic ok);
    ok = 1'b1;
    ch = 8'h00;
    if (d == 0) begin
      if (exp0.size() == 0) ok = 1'b0; else ch = exp0.pop_front();
    end else begin
      if (exp1.size() == 0) ok = 1'b0; else ch = exp1.pop_front();
    end
  endtask

  task automatic send(input int d, input logic [7:0] b);
    @(negedge clk);
    sc[d] = b;
    sv[d] = 1'b1;
    @(negedge clk);
    sv[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    logic [7:0] e;
    logic       ok;
    for (int i = 0; i < 12; i++) begin
      if (!rdy[d]) break;
      exp_pop(d, e, ok);
      if (!ok) check("extra_char", {24'h0, asc[d]}, 32'h0);
      else     check("fifo_char", {24'h0, asc[d]}, {24'h0, e});
      rd[d] = 1'b1;
      @(negedge clk);
      rd[d] = 1'b0;
    end
    check("drain_rdy", {31'h0, rdy[d]}, 32'h0);
    check("empty_ascii", {24'h0, asc[d]}, 32'h0);
    check("missing_chars", (d == 0) ? exp0.size() : exp1.size(), 32'h0);
  endtask

  function automatic void add(input int d, input logic [7:0] c, input logic p,
                              input logic [7:0] ch, input logic dr);
    vec_t v;
    v.d = d; v.code = c; v.push = p; v.ch = ch; v.drain = dr;
    vecs.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e;
    logic       ok;
    for (int i = 0; i < 2; i++) begin
      sc[i] = 8'h00; sv[i] = 1'b0; rd[i] = 1'b0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check("rst_ascii", {24'h0, asc[0]}, 32'h0);
    check("rst_rdy",   {31'h0, rdy[0]}, 32'h0);
    check("rst_full",  {31'h0, full[0]}, 32'h0);
    check("rst_ovf",   {31'h0, ovf[0]}, 32'h0);
    check("rst_mods",  {29'h0, sh[0], ct[0], cp[0]}, 32'h0);

    send(0, 8'h1C);
    exp_push(0, 8'h61);
    check("latency_rdy", {31'h0, rdy[0]}, 32'h1);
    check("latency_char", {24'h0, asc[0]}, 32'h61);
    send(0, 8'hF0);
    send(0, 8'h1C);
    drain(0);

    add(0, 8'h12, 0, 8'h00, 0); add(0, 8'h1C, 1, 8'h41, 0); add(0, 8'hF0, 0, 8'h00, 0);
    add(0, 8'h12, 0, 8'h00, 0); add(0, 8'h58, 0, 8'h00, 0); add(0, 8'hF0, 0, 8'h00, 0);
    add(0, 8'h58, 0, 8'h00, 0); add(0, 8'h1C, 1, 8'h41, 1);
    add(0, 8'h12, 0, 8'h00, 0); add(0, 8'h1C, 1, 8'h61, 0); add(0, 8'hF0, 0, 8'h00, 0);
    add(0, 8'h12, 0, 8'h00, 0); add(0, 8'h58, 0, 8'h00, 0); add(0, 8'h58, 0, 8'h00, 0);
    add(0, 8'hF0, 0, 8'h00, 0); add(0, 8'h58, 0, 8'h00, 0); add(0, 8'h1C, 1, 8'h61, 1);
    add(0, 8'h12, 0, 8'h00, 0); add(0, 8'h16, 1, 8'h21, 0); add(0, 8'hF0, 0, 8'h00, 0);
    add(0, 8'h12, 0, 8'h00, 0); add(0, 8'h16, 1, 8'h31, 0); add(0, 8'h4E, 1, 8'h2D, 0);
    add(0, 8'h12, 0, 8'h00, 0); add(0, 8'h4E, 1, 8'h5F, 0); add(0, 8'hF0, 0, 8'h00, 0);
    add(0, 8'h12, 0, 8'h00, 1);
    add(0, 8'hE0, 0, 8'h00, 0); add(0, 8'h75, 1, 8'h11, 0); add(0, 8'hE0, 0, 8'h00, 0);
    add(0, 8'hF0, 0, 8'h00, 0); add(0, 8'h75, 0, 8'h00, 0); add(0, 8'hE0, 0, 8'h00, 0);
    add(0, 8'h6B, 1, 8'h12, 0); add(0, 8'hE0, 0, 8'h00, 0); add(0, 8'h12, 0, 8'h00, 0);
    add(0, 8'hE0, 0, 8'h00, 0); add(0, 8'hF0, 0, 8'h00, 0); add(0, 8'h12, 0, 8'h00, 0);
    add(0, 8'hE0, 0, 8'h00, 0); add(0, 8'h5A, 1, 8'h0D, 0); add(0, 8'hE0, 0, 8'h00, 0);
    add(0, 8'h4A, 1, 8'h2F, 1);
    add(0, 8'h14, 0, 8'h00, 0); add(0, 8'h21, 1, 8'h03, 0); add(0, 8'hF0, 0, 8'h00, 0);
    add(0, 8'h14, 0, 8'h00, 0); add(0, 8'hE0, 0, 8'h00, 0); add(0, 8'h14, 0, 8'h00, 0);
    add(0, 8'h1C, 1, 8'h01, 0); add(0, 8'hE0, 0, 8'h00, 0); add(0, 8'hF0, 0, 8'h00, 0);
    add(0, 8'h14, 0, 8'h00, 0); add(0, 8'h1C, 1, 8'h61, 1);
    add(0, 8'h76, 1, 8'h1B, 0); add(0, 8'h29, 1, 8'h20, 0); add(0, 8'h5A, 1, 8'h0D, 0);
    add(0, 8'h66, 1, 8'h08, 1);
    add(0, 8'hAA, 0, 8'h00, 0); add(0, 8'hFA, 0, 8'h00, 0); add(0, 8'hEE, 0, 8'h00, 0);
    add(0, 8'hFE, 0, 8'h00, 0); add(0, 8'h0D, 1, 8'h09, 0); add(0, 8'h1A, 1, 8'h7A, 0);
    add(0, 8'h4A, 1, 8'h2F, 1);
    add(0, 8'hE0, 0, 8'h00, 0); add(0, 8'hE0, 0, 8'h00, 0); add(0, 8'h75, 1, 8'h11, 0);
    add(0, 8'hF0, 0, 8'h00, 0); add(0, 8'hF0, 0, 8'h00, 0); add(0, 8'h1C, 0, 8'h00, 0);
    add(0, 8'hF0, 0, 8'h00, 0); add(0, 8'hE0, 0, 8'h00, 0); add(0, 8'h75, 1, 8'h11, 0);
    add(0, 8'h1C, 1, 8'h61, 1);
    add(1, 8'h1C, 1, 8'h61, 0); add(1, 8'h1C, 0, 8'h00, 0); add(1, 8'h1C, 0, 8'h00, 0);
    add(1, 8'hF0, 0, 8'h00, 0); add(1, 8'h1C, 0, 8'h00, 0); add(1, 8'h1C, 1, 8'h61, 0);
    add(1, 8'h1C, 0, 8'h00, 0); add(1, 8'h32, 1, 8'h62, 0); add(1, 8'h1C, 1, 8'h61, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].d, vecs[i].code);
      if (vecs[i].push) begin
        exp_push(vecs[i].d, vecs[i].ch);
        check("push_rdy", {31'h0, rdy[vecs[i].d]}, 32'h1);
      end
      if (vecs[i].drain) drain(vecs[i].d);
    end

    send(0, 8'h12); check("lshift_on", {31'h0, sh[0]}, 32'h1);
    send(0, 8'h59);
    send(0, 8'hF0); send(0, 8'h12); check("rshift_held", {31'h0, sh[0]}, 32'h1);
    send(0, 8'hF0); send(0, 8'h59); check("shift_off", {31'h0, sh[0]}, 32'h0);
    send(0, 8'h58); check("caps_on", {31'h0, cp[0]}, 32'h1);
    send(0, 8'hF0); send(0, 8'h58);
    send(0, 8'h58); check("caps_off", {31'h0, cp[0]}, 32'h0);
    send(0, 8'hF0); send(0, 8'h58);
    send(0, 8'h14); send(0, 8'hE0); send(0, 8'h14);
    send(0, 8'hF0); send(0, 8'h14); check("rctrl_held", {31'h0, ct[0]}, 32'h1);
    send(0, 8'hE0); send(0, 8'hF0); send(0, 8'h14); check("ctrl_off", {31'h0, ct[0]}, 32'h0);
    check("mods_no_push", {31'h0, rdy[0]}, 32'h0);

    send(0, 8'h1C); exp_push(0, 8'h61);
    send(0, 8'h32); exp_push(0, 8'h62);
    send(0, 8'h21); exp_push(0, 8'h63);
    send(0, 8'h23); exp_push(0, 8'h64);
    check("full_set", {31'h0, full[0]}, 32'h1);
    check("ovf_idle", {31'h0, ovf[0]}, 32'h0);
    send(0, 8'h24);
    check("ovf_pulse", {31'h0, ovf[0]}, 32'h1);
    check("full_after_drop", {31'h0, full[0]}, 32'h1);
    @(negedge clk);
    check("ovf_one_cycle", {31'h0, ovf[0]}, 32'h0);
    exp_pop(0, e, ok);
    check("pushpop_head", {24'h0, asc[0]}, {24'h0, e});
    sc[0] = 8'h2B; sv[0] = 1'b1; rd[0] = 1'b1;
    exp_push(0, 8'h66);
    @(negedge clk);
    sv[0] = 1'b0; rd[0] = 1'b0;
    check("pushpop_full", {31'h0, full[0]}, 32'h1);
    check("pushpop_no_ovf", {31'h0, ovf[0]}, 32'h0);
    drain(0);

    send(0, 8'h12);
    send(0, 8'hE0);
    send(0, 8'hF0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check("rst_mid_shift", {31'h0, sh[0]}, 32'h0);
    send(0, 8'h1C); exp_push(0, 8'h61);
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
